led_fill_scheduler: RTL and testbench
=====================================

# led_fill_scheduler

Sequencer for the 13-segment LED fill bar. It divides CLOCK into fill ticks and runs the fill schedule: first segment after 12 ticks, one more segment every 7 ticks, all 13 lit at tick 96. It drives the bar renderer with a registered fill level, a one-cycle step strobe and a top-segment lock. It sits between the difficulty evaluator (3-bit mode) and the LED bar, and owns start, pause, restart and full detection.

## Interface
- TICK_DIV, default 10_000_000: CLOCK cycles per fill tick; must be ≥ 2.
- FIRST_TICK, default 12: tick count at which segment 1 lights.
- STEP_TICKS, default 7: ticks between subsequent segments.
- NUM_SEG, default 13: number of bar segments.
- CLOCK  in  1  system clock; all logic on its rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a fill run.
- pause  in  1  level; holds the schedule while high (only with LED_FILL_PAUSE_EN).
- mode  in  3  evaluator level; sampled only on an accepted start.
- fill_level  out  4  lit segments, 0..NUM_SEG.
- step  out  1  one-cycle strobe whenever fill_level changes.
- lock_top  out  1  top segment forced on (captured mode == 0).
- full  out  1  high while fill_level == NUM_SEG.
- busy  out  1  high in RUN or PAUSE.

## Operation
- States: IDLE, RUN, PAUSE, FULL. Reset state is IDLE.
- IDLE: start → RUN. Clears the prescaler, tick_cnt and fill_level, and captures mode.
- RUN: the prescaler counts 0..TICK_DIV-1. At wrap it pulses an internal tick and tick_cnt increments (7 bits, saturating at 127).
- fill_level = 0 while tick_cnt < FIRST_TICK; otherwise min(NUM_SEG, 1 + (tick_cnt−FIRST_TICK)/STEP_TICKS).
- The level is computed with a STEP_TICKS down-counter reloaded on each increment, not a divider.
- Defaults give level increments at ticks 12, 19, 26 … 89, 96.
- RUN: fill_level reaches NUM_SEG → FULL.
- RUN: pause high → PAUSE. The prescaler and tick_cnt freeze.
- PAUSE: pause low → RUN. Counting resumes from the frozen values; no tick is lost or duplicated.
- FULL: full=1, no further step. start → RUN (restart).
- start in any state restarts the run: counters clear and mode is re-captured.
- start and pause high in the same cycle: start wins and the next state is RUN.
- lock_top = (captured mode == 3'b000). It is independent of fill_level; the renderer ORs it onto the top segment.
- Reset mid-run aborts immediately and returns every output to its reset value.

## Timing
- Reset values: fill_level=0, step=0, lock_top=0, full=0, busy=0. State IDLE, all counters 0.
- start sampled at edge N → busy=1 and counters cleared at edge N.
- First tick occurs TICK_DIV cycles after the start edge.
- fill_level and step both update on the edge that registers the qualifying tick: zero added latency from tick to level.
- step is high for exactly one cycle per level increment. It is never high in IDLE, PAUSE or FULL.
- full rises on the same edge that fill_level becomes NUM_SEG. busy falls on that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- LED_FILL_PAUSE_EN defined: pause behaves as described and the PAUSE state exists.
- LED_FILL_PAUSE_EN undefined: the pause port remains but is ignored, the PAUSE state is not compiled, and RUN goes only to FULL or restarts.

## Structure
- Shared package led_pkg holds:
  - state enum led_fill_state_t (IDLE/RUN/PAUSE/FULL)
  - LED_NUM_SEG = 13
  - LED_FIRST_TICK = 12
  - LED_STEP_TICKS = 7
  - LED_LVL_W = 4
- One sub-module, led_tick_prescaler: parameter TICK_DIV; inputs enable and clear; output tick pulse.

## Test plan
- Reset mid-RUN at fill_level=5 → all outputs 0 in the reset cycle; state IDLE.
- TICK_DIV=4, start → first step at tick 12 (cycle 48 after start) with fill_level=1; fill_level=13, full=1, busy=0 at tick 96 (cycle 384); exactly 13 step pulses in total.
- mode=3'b000 at start → lock_top=1. Change mode mid-run to 3'b010 → lock_top stays 1. Restart with 3'b010 → lock_top=0.
- pause high for 50 cycles at tick 20 (LED_FILL_PAUSE_EN) → fill_level holds at 2, no step; final full arrives exactly 50 cycles later than in the unpaused run.
- start and pause asserted together in FULL → state RUN, fill_level=0, full=0.
- Build without LED_FILL_PAUSE_EN with pause tied high → timing identical to the unpaused run.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and default schedule constants for the LED fill bar sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FULL  = 2'd3
  } led_fill_state_t;

  localparam int LED_NUM_SEG    = 13;
  localparam int LED_FIRST_TICK = 12;
  localparam int LED_STEP_TICKS = 7;
  localparam int LED_LVL_W      = 4;
  localparam int LED_TICK_W     = 7;

endpackage

// File: rtl/led_fill_scheduler_if.sv
// Control/status bundle between the difficulty evaluator, the fill scheduler and the bar renderer.
interface led_fill_scheduler_if;
  import led_pkg::*;

  logic                 start;
  logic                 pause;
  logic [2:0]           mode;
  logic [LED_LVL_W-1:0] fill_level;
  logic                 step;
  logic                 lock_top;
  logic                 full;
  logic                 busy;

  modport master (
    output start, pause, mode,
    input  fill_level, step, lock_top, full, busy
  );

  modport slave (
    input  start, pause, mode,
    output fill_level, step, lock_top, full, busy
  );

endinterface

// File: rtl/led_tick_prescaler.sv
// Divides the system clock into single-cycle fill ticks; clear has priority over enable.
module led_tick_prescaler #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && !clear && (cnt_q == LAST);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_fill_scheduler.sv
// Fill-bar sequencer: schedules segment lighting from fill ticks; all outputs registered.
// Optional pause support is compiled in with `define LED_FILL_PAUSE_EN.
module led_fill_scheduler
  import led_pkg::*;
#(
  parameter int TICK_DIV   = 10_000_000,
  parameter int FIRST_TICK = LED_FIRST_TICK,
  parameter int STEP_TICKS = LED_STEP_TICKS,
  parameter int NUM_SEG    = LED_NUM_SEG
) (
  input logic                 CLOCK,
  input logic                 RESETN,
  led_fill_scheduler_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_FULL = FULL;
  localparam logic [LED_LVL_W-1:0]  LVL_FULL   = LED_LVL_W'(NUM_SEG);
  localparam logic [LED_TICK_W-1:0] FIRST_LAST = LED_TICK_W'(FIRST_TICK - 1);
  localparam logic [LED_TICK_W-1:0] STEP_LOAD  = LED_TICK_W'(STEP_TICKS);

  logic [1:0]            state_q, state_d;
  logic [LED_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [LED_TICK_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [LED_LVL_W-1:0]  fill_level_q, fill_level_d;
  logic                  step_q, step_d;
  logic                  lock_top_q, lock_top_d;
  logic                  full_q, full_d;
  logic                  busy_q, busy_d;
  logic                  active;
  logic                  tick;

`ifdef LED_FILL_PAUSE_EN
  localparam logic [1:0] S_PAUSE = PAUSE;
  // Counting stops in the very cycle pause is sampled high, so pause costs exactly its length.
  assign active = (state_q == S_RUN) || (state_q == S_PAUSE);
  logic pause_eff;
  assign pause_eff = bus.pause;
`else
  assign active = (state_q == S_RUN);
  logic pause_eff;
  assign pause_eff = 1'b0;
  logic unused_pause;
  assign unused_pause = bus.pause;
`endif

  led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (CLOCK),
    .rst_n  (RESETN),
    .enable (active && !pause_eff),
    .clear  (bus.start),
    .tick   (tick)
  );

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    seg_cnt_d    = seg_cnt_q;
    fill_level_d = fill_level_q;
    lock_top_d   = lock_top_q;
    step_d       = 1'b0;

    if (bus.start) begin
      state_d      = S_RUN;
      tick_cnt_d   = '0;
      seg_cnt_d    = '0;
      fill_level_d = '0;
      lock_top_d   = (bus.mode == 3'b000);
    end else begin
      if (tick) begin
        if (tick_cnt_q != '1) tick_cnt_d = tick_cnt_q + 1'b1;
        // Segment 1 keys off the absolute tick count; later segments off the reload counter.
        if (fill_level_q != LVL_FULL) begin
          if (tick_cnt_q == FIRST_LAST) begin
            fill_level_d = fill_level_q + 1'b1;
            seg_cnt_d    = STEP_LOAD;
            step_d       = 1'b1;
          end else if (fill_level_q != '0) begin
            if (seg_cnt_q == LED_TICK_W'(1)) begin
              fill_level_d = fill_level_q + 1'b1;
              seg_cnt_d    = STEP_LOAD;
              step_d       = 1'b1;
            end else begin
              seg_cnt_d = seg_cnt_q - 1'b1;
            end
          end
        end
      end

      case (state_q)
        S_RUN: begin
          if (fill_level_d == LVL_FULL) state_d = S_FULL;
`ifdef LED_FILL_PAUSE_EN
          else if (pause_eff)           state_d = S_PAUSE;
`endif
        end
`ifdef LED_FILL_PAUSE_EN
        S_PAUSE: begin
          if (fill_level_d == LVL_FULL) state_d = S_FULL;
          else if (!pause_eff)          state_d = S_RUN;
        end
`endif
        default: ;
      endcase
    end

    full_d = (fill_level_d == LVL_FULL);
`ifdef LED_FILL_PAUSE_EN
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
`else
    busy_d = (state_d == S_RUN);
`endif
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      seg_cnt_q    <= '0;
      fill_level_q <= '0;
      step_q       <= 1'b0;
      lock_top_q   <= 1'b0;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      seg_cnt_q    <= seg_cnt_d;
      fill_level_q <= fill_level_d;
      step_q       <= step_d;
      lock_top_q   <= lock_top_d;
      full_q       <= full_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.fill_level = fill_level_q;
  assign bus.step       = step_q;
  assign bus.lock_top   = lock_top_q;
  assign bus.full       = full_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_led_fill_scheduler.sv
// Directed bench for led_fill_scheduler with TICK_DIV=4 (one tick every 4 clocks).
module tb_led_fill_scheduler;
  import led_pkg::*;

  localparam int TDIV    = 4;
  localparam int FIRST_K = 12 * TDIV;  // 48
  localparam int FULL_K  = 96 * TDIV;  // 384
  localparam int SEG12_K = 89 * TDIV;  // 356

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  led_fill_scheduler_if bus ();

  led_fill_scheduler #(.TICK_DIV(TDIV)) dut (
    .CLOCK  (clk),
    .RESETN (rst_n),
    .bus    (bus)
  );

  task automatic pulse_start(input logic [2:0] m, input logic p_with, input logic p_after);
    @(negedge clk);
    bus.mode  = m;
    bus.start = 1'b1;
    bus.pause = p_with;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pause = p_after;
  endtask

  // Observes cycle k after the start edge until full rises or the budget expires.
  task automatic run_to_full(input int p_from, input int p_to, input logic p_tie,
                             output int full_k, output int n_steps, output int first_k,
                             output logic [3:0] first_lvl, output logic [3:0] lvl_before,
                             output logic [3:0] lvl_at, output int p_viol);
    full_k = -1; n_steps = 0; first_k = -1; first_lvl = '0; p_viol = 0;
    lvl_before = '0; lvl_at = '0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (bus.step === 1'b1) begin
        n_steps++;
        if (first_k < 0) begin first_k = k; first_lvl = bus.fill_level; end
      end
      if (k == SEG12_K - 1) lvl_before = bus.fill_level;
      if (k == SEG12_K)     lvl_at     = bus.fill_level;
      if (k > p_from && k <= p_to && (bus.step !== 1'b0 || bus.fill_level !== 4'd2 || bus.busy !== 1'b1))
        p_viol++;
      bus.pause = p_tie || (k >= p_from && k < p_to);
      if (bus.full === 1'b1) begin full_k = k; break; end
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_total++; if (bus.fill_level !== 4'd0) $display("FAIL reset_level got %0d want 0", bus.fill_level); else n_pass++;
    n_total++; if (bus.step !== 1'b0) $display("FAIL reset_step got %b want 0", bus.step); else n_pass++;
    n_total++; if (bus.lock_top !== 1'b0) $display("FAIL reset_lock got %b want 0", bus.lock_top); else n_pass++;
    n_total++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.full); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0 || bus.step !== 1'b0) $display("FAIL idle_hold busy=%b step=%b want 0 0", bus.busy, bus.step); else n_pass++;
  endtask

  task automatic test_fill;
    int fk, ns, f1; logic [3:0] fl, lb, la; int pv;
    pulse_start(3'b101, 1'b0, 1'b0);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL start_busy got %b want 1", bus.busy); else n_pass++;
    run_to_full(-1, -1, 1'b0, fk, ns, f1, fl, lb, la, pv);
    n_total++; if (f1 !== FIRST_K) $display("FAIL first_step_cycle got %0d want %0d", f1, FIRST_K); else n_pass++;
    n_total++; if (fl !== 4'd1) $display("FAIL first_step_level got %0d want 1", fl); else n_pass++;
    n_total++; if (lb !== 4'd11) $display("FAIL level_before_seg12 got %0d want 11", lb); else n_pass++;
    n_total++; if (la !== 4'd12) $display("FAIL level_at_seg12 got %0d want 12", la); else n_pass++;
    n_total++; if (fk !== FULL_K) $display("FAIL full_cycle got %0d want %0d", fk, FULL_K); else n_pass++;
    n_total++; if (ns !== 13) $display("FAIL step_count got %0d want 13", ns); else n_pass++;
    n_total++; if (bus.fill_level !== 4'd13) $display("FAIL full_level got %0d want 13", bus.fill_level); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL full_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.lock_top !== 1'b0) $display("FAIL lock_mode5 got %b want 0", bus.lock_top); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.step !== 1'b0 || bus.full !== 1'b1) $display("FAIL full_hold step=%b full=%b want 0 1", bus.step, bus.full); else n_pass++;
  endtask

  task automatic test_lock_top;
    pulse_start(3'b000, 1'b0, 1'b0);
    n_total++; if (bus.lock_top !== 1'b1) $display("FAIL lock_mode0 got %b want 1", bus.lock_top); else n_pass++;
    n_total++; if (bus.full !== 1'b0 || bus.fill_level !== 4'd0) $display("FAIL restart_from_full full=%b lvl=%0d want 0 0", bus.full, bus.fill_level); else n_pass++;
    bus.mode = 3'b010;
    repeat (60) @(negedge clk);
    n_total++; if (bus.lock_top !== 1'b1) $display("FAIL lock_midrun got %b want 1", bus.lock_top); else n_pass++;
    n_total++; if (bus.fill_level !== 4'd1) $display("FAIL level_at_61 got %0d want 1", bus.fill_level); else n_pass++;
    pulse_start(3'b010, 1'b0, 1'b0);
    n_total++; if (bus.lock_top !== 1'b0) $display("FAIL lock_restart got %b want 0", bus.lock_top); else n_pass++;
    n_total++; if (bus.fill_level !== 4'd0 || bus.busy !== 1'b1) $display("FAIL restart_run lvl=%0d busy=%b want 0 1", bus.fill_level, bus.busy); else n_pass++;
  endtask

  task automatic test_pause;
    int fk, ns, f1; logic [3:0] fl, lb, la; int pv;
    int exp_k;
`ifdef LED_FILL_PAUSE_EN
    exp_k = FULL_K + 50;
`else
    exp_k = FULL_K;
`endif
    pulse_start(3'b001, 1'b0, 1'b0);
    run_to_full(20 * TDIV, 20 * TDIV + 50, 1'b0, fk, ns, f1, fl, lb, la, pv);
    n_total++; if (fk !== exp_k) $display("FAIL pause_full_cycle got %0d want %0d", fk, exp_k); else n_pass++;
    n_total++; if (ns !== 13) $display("FAIL pause_step_count got %0d want 13", ns); else n_pass++;
`ifdef LED_FILL_PAUSE_EN
    n_total++; if (pv !== 0) $display("FAIL pause_hold violations got %0d want 0", pv); else n_pass++;
`endif
  endtask

  task automatic test_start_pause_in_full;
    n_total++; if (bus.full !== 1'b1) $display("FAIL pre_full got %b want 1", bus.full); else n_pass++;
    pulse_start(3'b011, 1'b1, 1'b0);
    n_total++; if (bus.busy !== 1'b1 || bus.full !== 1'b0) $display("FAIL start_wins busy=%b full=%b want 1 0", bus.busy, bus.full); else n_pass++;
    n_total++; if (bus.fill_level !== 4'd0 || bus.step !== 1'b0) $display("FAIL start_wins_lvl lvl=%0d step=%b want 0 0", bus.fill_level, bus.step); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL run_after_start got %b want 1", bus.busy); else n_pass++;
  endtask

`ifndef LED_FILL_PAUSE_EN
  task automatic test_pause_ignored;
    int fk, ns, f1; logic [3:0] fl, lb, la; int pv;
    pulse_start(3'b100, 1'b0, 1'b1);
    run_to_full(-1, -1, 1'b1, fk, ns, f1, fl, lb, la, pv);
    n_total++; if (fk !== FULL_K) $display("FAIL tied_pause_full got %0d want %0d", fk, FULL_K); else n_pass++;
    n_total++; if (f1 !== FIRST_K || ns !== 13) $display("FAIL tied_pause_steps first=%0d n=%0d want %0d 13", f1, ns, FIRST_K); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_run;
    int k;
    pulse_start(3'b000, 1'b0, 1'b0);
    k = 0;
    while (k < 400 && bus.fill_level !== 4'd5) begin
      @(negedge clk); k++;
    end
    n_total++; if (k !== 40 * TDIV) $display("FAIL level5_cycle got %0d want %0d", k, 40 * TDIV); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.fill_level !== 4'd0 || bus.step !== 1'b0) $display("FAIL rst_mid lvl=%0d step=%b want 0 0", bus.fill_level, bus.step); else n_pass++;
    n_total++; if (bus.lock_top !== 1'b0 || bus.full !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst_mid lock=%b full=%b busy=%b want 0 0 0", bus.lock_top, bus.full, bus.busy); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (TDIV * 15) @(negedge clk);
    n_total++; if (bus.busy !== 1'b0 || bus.fill_level !== 4'd0) $display("FAIL post_rst_idle busy=%b lvl=%0d want 0 0", bus.busy, bus.fill_level); else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.mode  = 3'b000;
    test_reset();
    test_fill();
    test_lock_top();
    test_pause();
    test_start_pause_in_full();
`ifndef LED_FILL_PAUSE_EN
    test_pause_ignored();
`endif
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
